// File: rtl/snax_csr_launcher_pkg.sv
// Shared definitions for the SimbaCore CSR launcher: register map offsets
// (relative to the number of staging registers) and the launch FSM states.
package snax_csr_launcher_pkg;

  typedef enum logic {
    LAUNCH_IDLE    = 1'b0,
    LAUNCH_PENDING = 1'b1
  } launch_state_e;

  function automatic int unsigned start_ofs(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned status_ofs(input int unsigned n);
    return n + 1;
  endfunction

  function automatic int unsigned stall_ofs(input int unsigned n);
    return n + 2;
  endfunction

  function automatic int unsigned ro_base(input int unsigned n);
    return n + 3;
  endfunction

endpackage

// File: rtl/snax_simbacore_csr_launcher.sv
// CSR launch controller: staging registers are snapshotted into a shadow set
// on START and handed to the SimbaCore shell through a valid/ready launch.
//
// state          | meaning
// LAUNCH_IDLE    | no launch outstanding, START writes accepted
// LAUNCH_PENDING | shadow set presented, waiting for csr_reg_set_ready_i
module snax_simbacore_csr_launcher
  import snax_csr_launcher_pkg::*;
#(
  parameter int unsigned NumRwCsr     = 5,
  parameter int unsigned NumRoCsr     = 1,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [RegAddrWidth-1:0]                  csr_req_addr_i,
  input  logic [RegDataWidth-1:0]                  csr_req_data_i,
  input  logic                                     csr_req_write_i,
  input  logic                                     csr_req_valid_i,
  output logic                                     csr_req_ready_o,
  output logic [RegDataWidth-1:0]                  csr_rsp_data_o,
  output logic                                     csr_rsp_valid_o,
  input  logic                                     csr_rsp_ready_i,
  output logic [NumRwCsr-1:0][RegDataWidth-1:0]    csr_reg_rw_set_o,
  output logic                                     csr_reg_set_valid_o,
  input  logic                                     csr_reg_set_ready_i,
  input  logic [NumRoCsr-1:0][RegDataWidth-1:0]    csr_reg_ro_set_i
);

  localparam logic [RegAddrWidth-1:0] AddrStart  = RegAddrWidth'(start_ofs(NumRwCsr));
  localparam logic [RegAddrWidth-1:0] AddrStatus = RegAddrWidth'(status_ofs(NumRwCsr));
  localparam logic [RegAddrWidth-1:0] AddrStall  = RegAddrWidth'(stall_ofs(NumRwCsr));
  localparam logic [RegAddrWidth-1:0] AddrRoBase = RegAddrWidth'(ro_base(NumRwCsr));

  launch_state_e             state_q, state_d;
  logic [RegDataWidth-1:0]   staging_q [NumRwCsr];
  logic [RegDataWidth-1:0]   shadow_q  [NumRwCsr];
  logic [31:0]               stall_cnt_q;
  logic                      rsp_valid_q;
  logic [RegDataWidth-1:0]   rsp_data_q;
  logic [RegDataWidth-1:0]   rd_data;
  logic                      launch_pending;
  logic                      addr_is_start;
  logic                      req_fire;
  logic                      wr_fire;
  logic                      rd_fire;
  logic                      start_go;

  assign launch_pending = (state_q == LAUNCH_PENDING);
  assign addr_is_start  = (csr_req_addr_i == AddrStart);

  // A second START must not overwrite the shadow set while the shell has not taken it.
  assign csr_req_ready_o = !rsp_valid_q && !(csr_req_write_i && addr_is_start && launch_pending);

  assign req_fire = csr_req_valid_i && csr_req_ready_o;
  assign wr_fire  = req_fire && csr_req_write_i;
  assign rd_fire  = req_fire && !csr_req_write_i;
  assign start_go = wr_fire && addr_is_start && csr_req_data_i[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LAUNCH_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LAUNCH_IDLE:    if (start_go) state_d = LAUNCH_PENDING;
      LAUNCH_PENDING: if (csr_reg_set_ready_i) state_d = LAUNCH_IDLE;
      default:        state_d = LAUNCH_IDLE;
    endcase
  end

  assign csr_reg_set_valid_o = launch_pending;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (start_go) begin
      stall_cnt_q <= '0;
    end else if (launch_pending && !csr_reg_set_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  for (genvar k = 0; k < NumRwCsr; k++) begin : g_rw
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        staging_q[k] <= '0;
        shadow_q[k]  <= '0;
      end else begin
        if (wr_fire && (csr_req_addr_i == RegAddrWidth'(k))) staging_q[k] <= csr_req_data_i;
        if (start_go) shadow_q[k] <= staging_q[k];
      end
    end
    assign csr_reg_rw_set_o[k] = shadow_q[k];
  end

  // START and unmapped addresses fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NumRwCsr; k++) begin
      if (csr_req_addr_i == RegAddrWidth'(k)) rd_data = staging_q[k];
    end
    if (csr_req_addr_i == AddrStatus) rd_data = {{(RegDataWidth-1){1'b0}}, launch_pending};
    if (csr_req_addr_i == AddrStall)  rd_data = RegDataWidth'(stall_cnt_q);
    for (int k = 0; k < NumRoCsr; k++) begin
      if (csr_req_addr_i == AddrRoBase + RegAddrWidth'(k)) rd_data = csr_reg_ro_set_i[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rd_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rd_data;
    end else if (rsp_valid_q && csr_rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign csr_rsp_valid_o = rsp_valid_q;
  assign csr_rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_snax_simbacore_csr_launcher.sv
// Directed bench for the SimbaCore CSR launcher: a table of register accesses
// followed by hand-written launch, backpressure and reset sequences.
module tb_snax_simbacore_csr_launcher;

  localparam int N = 5;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [31:0]      csr_req_addr_i;
  logic [31:0]      csr_req_data_i;
  logic             csr_req_write_i;
  logic             csr_req_valid_i;
  logic             csr_req_ready_o;
  logic [31:0]      csr_rsp_data_o;
  logic             csr_rsp_valid_o;
  logic             csr_rsp_ready_i;
  logic [N-1:0][31:0] csr_reg_rw_set_o;
  logic             csr_reg_set_valid_o;
  logic             csr_reg_set_ready_i;
  logic [0:0][31:0] csr_reg_ro_set_i;

  int checks = 0;
  int errors = 0;

  snax_simbacore_csr_launcher #(
    .NumRwCsr(N), .NumRoCsr(1), .RegDataWidth(32), .RegAddrWidth(32)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .csr_req_addr_i      (csr_req_addr_i),
    .csr_req_data_i      (csr_req_data_i),
    .csr_req_write_i     (csr_req_write_i),
    .csr_req_valid_i     (csr_req_valid_i),
    .csr_req_ready_o     (csr_req_ready_o),
    .csr_rsp_data_o      (csr_rsp_data_o),
    .csr_rsp_valid_o     (csr_rsp_valid_o),
    .csr_rsp_ready_i     (csr_rsp_ready_i),
    .csr_reg_rw_set_o    (csr_reg_rw_set_o),
    .csr_reg_set_valid_o (csr_reg_set_valid_o),
    .csr_reg_set_ready_i (csr_reg_set_ready_i),
    .csr_reg_ro_set_i    (csr_reg_ro_set_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic bus_req(input logic [31:0] a, input logic w, input logic [31:0] d);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    csr_req_addr_i  = a;
    csr_req_write_i = w;
    csr_req_data_i  = d;
    csr_req_valid_i = 1'b1;
    while (!done) begin
      #1;
      done = csr_req_ready_o;
      @(negedge clk_i);
      n++;
      if (!done && n >= 40) begin
        check("req_timeout", 32'(csr_req_ready_o), 32'd1);
        done = 1;
      end
    end
    csr_req_valid_i = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus_req(a, 1'b0, 32'd0);
    check({name, "_rvalid"}, 32'(csr_rsp_valid_o), 32'd1);
    check(name, csr_rsp_data_o, exp);
    @(negedge clk_i);
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{addr: 0,      write: 1, data: 32'd1, exp: 0};
    vecs[1]  = '{addr: 1,      write: 1, data: 32'd2, exp: 0};
    vecs[2]  = '{addr: 2,      write: 1, data: 32'd3, exp: 0};
    vecs[3]  = '{addr: 3,      write: 1, data: 32'd4, exp: 0};
    vecs[4]  = '{addr: 4,      write: 1, data: 32'd5, exp: 0};
    vecs[5]  = '{addr: 2,      write: 0, data: 0,     exp: 32'd3};
    vecs[6]  = '{addr: 4,      write: 0, data: 0,     exp: 32'd5};
    vecs[7]  = '{addr: N,      write: 0, data: 0,     exp: 32'd0};
    vecs[8]  = '{addr: N+1,    write: 0, data: 0,     exp: 32'd0};
    vecs[9]  = '{addr: N+3,    write: 0, data: 0,     exp: 32'hDEAD_BEEF};
    vecs[10] = '{addr: 32'h40, write: 0, data: 0,     exp: 32'd0};
    vecs[11] = '{addr: N+3,    write: 1, data: 32'h1234, exp: 0};

    rst_i               = 1'b1;
    csr_req_addr_i      = '0;
    csr_req_data_i      = '0;
    csr_req_write_i     = 1'b0;
    csr_req_valid_i     = 1'b0;
    csr_rsp_ready_i     = 1'b1;
    csr_reg_set_ready_i = 1'b0;
    csr_reg_ro_set_i[0] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    check("rst_set_valid", 32'(csr_reg_set_valid_o), 32'd0);
    check("rst_rsp_valid", 32'(csr_rsp_valid_o), 32'd0);
    check("rst_rsp_data", csr_rsp_data_o, 32'd0);
    check("rst_req_ready", 32'(csr_req_ready_o), 32'd1);
    for (int k = 0; k < N; k++) check($sformatf("rst_shadow%0d", k), csr_reg_rw_set_o[k], 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].write) bus_req(vecs[i].addr, 1'b1, vecs[i].data);
      else read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    // A write to the RO window must be ignored.
    read_check("ro_after_write", N+3, 32'hDEAD_BEEF);
    read_check("stall_idle", N+2, 32'd0);
    check("no_launch_yet", 32'(csr_reg_set_valid_o), 32'd0);

    // Launch with 3 stall cycles, staging write and STATUS read while pending.
    bus_req(N, 1'b1, 32'd1);
    check("launch_valid", 32'(csr_reg_set_valid_o), 32'd1);
    for (int k = 0; k < N; k++) check($sformatf("launch_shadow%0d", k), csr_reg_rw_set_o[k], 32'(k + 1));
    bus_req(2, 1'b1, 32'hAA);
    check("pending_shadow2", csr_reg_rw_set_o[2], 32'd3);
    check("pending_valid", 32'(csr_reg_set_valid_o), 32'd1);
    read_check("status_pending", N+1, 32'd1);
    csr_req_addr_i      = N;
    csr_req_write_i     = 1'b1;
    csr_req_data_i      = 32'd1;
    csr_req_valid_i     = 1'b1;
    csr_reg_set_ready_i = 1'b1;
    #1;
    check("start_stalled", 32'(csr_req_ready_o), 32'd0);
    @(negedge clk_i);
    csr_reg_set_ready_i = 1'b0;
    #1;
    check("valid_dropped", 32'(csr_reg_set_valid_o), 32'd0);
    check("start_ready_after", 32'(csr_req_ready_o), 32'd1);
    csr_req_valid_i = 1'b0;
    @(negedge clk_i);
    read_check("stall_cnt", N+2, 32'd3);
    read_check("status_idle", N+1, 32'd0);

    // Second launch presents the value written while pending; immediate handshake.
    bus_req(N, 1'b1, 32'd1);
    check("relaunch_valid", 32'(csr_reg_set_valid_o), 32'd1);
    check("relaunch_shadow2", csr_reg_rw_set_o[2], 32'hAA);
    check("relaunch_shadow0", csr_reg_rw_set_o[0], 32'd1);
    csr_reg_set_ready_i = 1'b1;
    @(negedge clk_i);
    csr_reg_set_ready_i = 1'b0;
    check("relaunch_done", 32'(csr_reg_set_valid_o), 32'd0);
    read_check("stall_zero", N+2, 32'd0);

    // Response backpressure with a second read waiting.
    csr_rsp_ready_i = 1'b0;
    bus_req(0, 1'b0, 32'd0);
    csr_req_addr_i  = 1;
    csr_req_write_i = 1'b0;
    csr_req_valid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("bp_valid%0d", c), 32'(csr_rsp_valid_o), 32'd1);
      check($sformatf("bp_data%0d", c), csr_rsp_data_o, 32'd1);
      check($sformatf("bp_ready%0d", c), 32'(csr_req_ready_o), 32'd0);
      @(negedge clk_i);
    end
    csr_rsp_ready_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("bp_consumed", 32'(csr_rsp_valid_o), 32'd0);
    check("bp_next_ready", 32'(csr_req_ready_o), 32'd1);
    @(negedge clk_i);
    csr_req_valid_i = 1'b0;
    check("b2b_valid", 32'(csr_rsp_valid_o), 32'd1);
    check("b2b_data", csr_rsp_data_o, 32'd2);
    @(negedge clk_i);

    // START with bit0 clear is a no-op.
    bus_req(0, 1'b1, 32'h77);
    bus_req(N, 1'b1, 32'd0);
    check("start0_valid", 32'(csr_reg_set_valid_o), 32'd0);
    check("start0_shadow0", csr_reg_rw_set_o[0], 32'd1);

    // Reset while pending with a response outstanding.
    bus_req(N, 1'b1, 32'd1);
    check("pre_rst_shadow0", csr_reg_rw_set_o[0], 32'h77);
    csr_rsp_ready_i = 1'b0;
    bus_req(N+1, 1'b0, 32'd0);
    check("pre_rst_rsp", 32'(csr_rsp_valid_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_set_valid", 32'(csr_reg_set_valid_o), 32'd0);
    check("mid_rst_rsp_valid", 32'(csr_rsp_valid_o), 32'd0);
    check("mid_rst_rsp_data", csr_rsp_data_o, 32'd0);
    check("mid_rst_req_ready", 32'(csr_req_ready_o), 32'd1);
    for (int k = 0; k < N; k++) check($sformatf("mid_rst_shadow%0d", k), csr_reg_rw_set_o[k], 32'd0);
    rst_i = 1'b0;
    csr_rsp_ready_i = 1'b1;
    @(negedge clk_i);
    read_check("post_rst_staging0", 0, 32'd0);
    read_check("post_rst_stall", N+2, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
